// File: rtl/udp_tx_scheduler_if.sv
// Bus between the payload producers, the TX frame scheduler and the downstream
// header/CRC builder. The master modport is the scheduler; the slave modport is the surrounding logic.
interface udp_tx_scheduler_if #(
    parameter int N_SRC = 2
);
    logic [N_SRC-1:0]    src_req;
    logic [11*N_SRC-1:0] src_len;
    logic [N_SRC-1:0]    src_grant;
    logic [8*N_SRC-1:0]  src_data;
    logic [N_SRC-1:0]    src_valid;
    logic [N_SRC-1:0]    src_ready;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [2:0]          tx_phase;
    logic [10:0]         tx_idx;
    logic                tx_last;
    logic [2:0]          tx_src;
    logic [10:0]         tx_len;
    logic                len_err;

    modport master (
        input  src_req, src_len, src_data, src_valid, tx_ready,
        output src_grant, src_ready, tx_data, tx_valid, tx_phase,
               tx_idx, tx_last, tx_src, tx_len, len_err
    );

    modport slave (
        output src_req, src_len, src_data, src_valid, tx_ready,
        input  src_grant, src_ready, tx_data, tx_valid, tx_phase,
               tx_idx, tx_last, tx_src, tx_len, len_err
    );
endinterface

// File: rtl/udp_tx_scheduler.sv
// Arbitrates N_SRC payload sources onto one UDP/IP/Ethernet frame builder and sequences the frame phases.
// Optional macro SCHED_STRICT_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module udp_tx_scheduler #(
    parameter int N_SRC       = 2,
    parameter int MAX_PAYLOAD = 1472,
    parameter int IFG_CYCLES  = 12
) (
    input logic                clk_i,
    input logic                rst_i,
    udp_tx_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ETH = 3'd1, S_IP = 3'd2, S_UDP = 3'd3,
        S_PAY  = 3'd4, S_FCS = 3'd5, S_GAP = 3'd6
    } state_t;

    localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
    localparam logic [10:0] MIN_PAY  = 11'd18;
    localparam logic [15:0] GAP_LOAD = 16'(IFG_CYCLES - 1);

    state_t            state_q, state_d;
    logic [10:0]       idx_q, idx_d, len_q, len_d;
    logic [N_SRC-1:0]  grant_q, grant_d;
    logic [2:0]        src_q, src_d, rr_q, rr_d;
    logic [15:0]       gap_q, gap_d;
    logic              len_err_q, len_err_d;

    logic              win_found, req_err, hit;
    logic [2:0]        win, rr_adv;
    logic [10:0]       win_len, phase_last, pay_last;
    logic [7:0]        sel_data;
    logic              sel_valid, pay_byte, tx_valid, fire, phase_done;

    always_comb begin
        int c;
        c         = 0;
        win_found = 1'b0;
        req_err   = 1'b0;
        hit       = 1'b0;
        win       = '0;
        win_len   = '0;
        rr_adv    = rr_q;
`ifdef SCHED_STRICT_PRIO_EN
        for (int i = 0; i < N_SRC; i++) begin
            if (!win_found && bus.src_req[i]) begin
                if (bus.src_len[11*i +: 11] > MAX_LEN) begin
                    req_err = 1'b1;
                end else begin
                    win_found = 1'b1;
                    win       = 3'(i);
                    win_len   = bus.src_len[11*i +: 11];
                end
            end
        end
`else
        // One requester is examined per arbitration cycle; an oversize one only moves the pointer.
        for (int off = 0; off < N_SRC; off++) begin
            c = (int'(rr_q) + off) % N_SRC;
            if (!hit && bus.src_req[c]) begin
                hit    = 1'b1;
                rr_adv = 3'((c + 1) % N_SRC);
                if (bus.src_len[11*c +: 11] > MAX_LEN) begin
                    req_err = 1'b1;
                end else begin
                    win_found = 1'b1;
                    win       = 3'(c);
                    win_len   = bus.src_len[11*c +: 11];
                end
            end
        end
`endif
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_q == 3'(i)) begin
                sel_data  = bus.src_data[8*i +: 8];
                sel_valid = bus.src_valid[i];
            end
        end
    end

    assign pay_last = ((len_q > MIN_PAY) ? len_q : MIN_PAY) - 11'd1;
    assign pay_byte = (state_q == S_PAY) && (idx_q < len_q);

    always_comb begin
        tx_valid   = 1'b1;
        phase_last = '0;
        case (state_q)
            S_IDLE, S_GAP: tx_valid = 1'b0;
            S_ETH:   phase_last = 11'd13;
            S_IP:    phase_last = 11'd19;
            S_UDP:   phase_last = 11'd7;
            S_PAY: begin
                phase_last = pay_last;
                tx_valid   = pay_byte ? sel_valid : 1'b1;
            end
            S_FCS:   phase_last = 11'd3;
            default: tx_valid = 1'b0;
        endcase
    end

    assign fire       = tx_valid && bus.tx_ready;
    assign phase_done = fire && (idx_q == phase_last);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        grant_d   = grant_q;
        src_d     = src_q;
        len_d     = len_q;
        rr_d      = rr_q;
        gap_d     = gap_q;
        len_err_d = 1'b0;
        if (fire) begin
            idx_d = phase_done ? 11'd0 : idx_q + 11'd1;
        end
        case (state_q)
            S_IDLE: begin
                len_err_d = req_err;
                rr_d      = rr_adv;
                if (win_found) begin
                    state_d = S_ETH;
                    src_d   = win;
                    len_d   = win_len;
                    for (int i = 0; i < N_SRC; i++) begin
                        grant_d[i] = (i == int'(win));
                    end
                end
            end
            S_ETH: if (phase_done) state_d = S_IP;
            S_IP:  if (phase_done) state_d = S_UDP;
            S_UDP: if (phase_done) state_d = S_PAY;
            S_PAY: if (phase_done) state_d = S_FCS;
            S_FCS: begin
                if (phase_done) begin
                    state_d = S_GAP;
                    grant_d = '0;
                    src_d   = '0;
                    len_d   = '0;
                    gap_d   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (gap_q == 16'd0) state_d = S_IDLE;
                else                gap_d   = gap_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            grant_q   <= '0;
            src_q     <= '0;
            len_q     <= '0;
            rr_q      <= '0;
            gap_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            src_q     <= src_d;
            len_q     <= len_d;
            rr_q      <= rr_d;
            gap_q     <= gap_d;
            len_err_q <= len_err_d;
        end
    end

    // The gap state is internal; downstream only ever sees IDLE between frames.
    assign bus.tx_phase  = (state_q == S_GAP) ? 3'd0 : state_q;
    assign bus.tx_valid  = tx_valid;
    assign bus.tx_data   = pay_byte ? sel_data : 8'd0;
    assign bus.src_ready = (pay_byte && bus.tx_ready) ? grant_q : '0;
    assign bus.tx_idx    = idx_q;
    assign bus.tx_last   = (state_q == S_FCS) && (idx_q == 11'd3);
    assign bus.tx_src    = src_q;
    assign bus.tx_len    = len_q;
    assign bus.src_grant = grant_q;
    assign bus.len_err   = len_err_q;
endmodule
